// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between two sram-like
// requesters. An order FIFO of requester ids routes each data_ok back to the
// requester that issued the matching address phase, in issue order.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise m0 has fixed priority.
module sram_like_arbiter #(
    parameter int ORD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    localparam int PW = $clog2(ORD_DEPTH);

    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [PW:0]        count;
    logic [ORD_DEPTH-1:0] order_mem;
    logic               last_grant;

    logic               sel;
    logic               full;
    logic               empty;
    logic               head;
    logic               push;
    logic               pop;

    assign full  = (count == (PW+1)'(ORD_DEPTH));
    assign empty = (count == '0);
    assign head  = order_mem[rptr];

    // Pick the winning requester; last_grant only matters when both request
    always_comb begin
        sel = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req)
            sel = ~last_grant;
        else
            sel = m1_req;
`else
        sel = m0_req ? 1'b0 : m1_req;
`endif
    end

    // Address phase mux toward the shared port; full blocks new requests with no bypass from a same-cycle pop
    always_comb begin
        s_req   = 1'b0;
        s_wr    = m0_wr;
        s_size  = m0_size;
        s_addr  = m0_addr;
        s_wstrb = m0_wstrb;
        s_wdata = m0_wdata;
        if (sel) begin
            s_req   = m1_req && !full;
            s_wr    = m1_wr;
            s_size  = m1_size;
            s_addr  = m1_addr;
            s_wstrb = m1_wstrb;
            s_wdata = m1_wdata;
        end else begin
            s_req   = m0_req && !full;
        end
    end

    assign push = s_req && s_addr_ok;
    assign pop  = s_data_ok && !empty;

    // Handshakes pass straight through; data_ok follows the FIFO head, stray data_ok while empty is dropped
    always_comb begin
        m0_addr_ok = (sel == 1'b0) && m0_req && s_addr_ok && !full;
        m1_addr_ok = (sel == 1'b1) && m1_req && s_addr_ok && !full;
        m0_data_ok = pop && (head == 1'b0);
        m1_data_ok = pop && (head == 1'b1);
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
    end

    // Order FIFO and grant history; concurrent push and pop keep the count and move both pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            order_mem  <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                order_mem[wptr] <= sel;
                wptr            <= wptr + 1'b1;
                last_grant      <= sel;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios for sram_like_arbiter with
// hand-computed expectations (ORD_DEPTH = 4). Honours ARB_ROUND_ROBIN_EN.
module tb_sram_like_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;

    int errors;
    int checks;

    sram_like_arbiter #(.ORD_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_size = 2'd2; m0_addr = 32'h1000; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        m1_req = 0; m1_wr = 1; m1_size = 2'd1; m1_addr = 32'h2000; m1_wstrb = 4'h3; m1_wdata = 32'h0000_5A5A;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 32'h0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        s_addr_ok = 1; s_data_ok = 1;
        #2;
        checks++; if (s_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_req got=%b exp=0", s_req); end
        checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset_addr_ok got=%b exp=00", {m0_addr_ok, m1_addr_ok}); end
        checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset_data_ok got=%b exp=00", {m0_data_ok, m1_data_ok}); end
        next_cycle();
        idle();
        reset = 0;
        next_cycle();
    endtask

    task automatic test_arbitration();
        logic [2:0] exp0;
        apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
        exp0 = 3'b101;
`else
        exp0 = 3'b111;
`endif
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if ({m0_addr_ok, m1_addr_ok} !== {exp0[2-i], ~exp0[2-i]}) begin
                errors++;
                $display("[TB] FAIL arb_cycle%0d got=%b exp=%b", i + 1, {m0_addr_ok, m1_addr_ok}, {exp0[2-i], ~exp0[2-i]});
            end
            next_cycle();
        end
        // m1 alone: check the shared-port field mux
        m0_req = 0;
        #2;
        checks++;
        if ({s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata, m1_addr_ok} !== {1'b1, 1'b1, 2'd1, 32'h2000, 4'h3, 32'h0000_5A5A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mux_m1 got req=%b wr=%b size=%0d addr=%h strb=%h wdata=%h aok=%b exp 1 1 1 00002000 3 00005a5a 1",
                     s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata, m1_addr_ok);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_order();
        apply_reset();
        m0_req = 1; m0_wr = 0; m0_addr = 32'h1000; s_addr_ok = 1;
        #2;
        checks++; if ({s_req, s_wr, s_addr, m0_addr_ok} !== {1'b1, 1'b0, 32'h1000, 1'b1}) begin errors++; $display("[TB] FAIL order_m0_accept got req=%b wr=%b addr=%h aok=%b", s_req, s_wr, s_addr, m0_addr_ok); end
        next_cycle();
        m0_req = 0; m1_req = 1;
        #2;
        checks++; if (m1_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL order_m1_accept got=%b exp=1", m1_addr_ok); end
        next_cycle();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        #2;
        checks++; if ({m0_data_ok, m1_data_ok, m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL order_first got dok=%b rdata=%h exp 10 deadbeef", {m0_data_ok, m1_data_ok}, m0_rdata); end
        next_cycle();
        s_rdata = 32'h1234_5678;
        #2;
        checks++; if ({m0_data_ok, m1_data_ok, m1_rdata} !== {2'b01, 32'h1234_5678}) begin errors++; $display("[TB] FAIL order_second got dok=%b rdata=%h exp 01 12345678", {m0_data_ok, m1_data_ok}, m1_rdata); end
        next_cycle();
        #2;
        checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL empty_data_ok got=%b exp=00", {m0_data_ok, m1_data_ok}); end
        next_cycle();
        idle();
    endtask

    task automatic test_full();
        apply_reset();
        m0_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (m0_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL fill_accept%0d got=%b exp=1", i, m0_addr_ok); end
            next_cycle();
        end
        s_data_ok = 1; s_rdata = 32'hCAFE_0001;
        #2;
        checks++; if ({s_req, m0_addr_ok, m0_data_ok} !== 3'b001) begin errors++; $display("[TB] FAIL full_no_bypass got req/aok/dok=%b exp=001", {s_req, m0_addr_ok, m0_data_ok}); end
        next_cycle();
        s_data_ok = 0;
        #2;
        checks++; if ({s_req, m0_addr_ok} !== 2'b11) begin errors++; $display("[TB] FAIL after_full_accept got=%b exp=11", {s_req, m0_addr_ok}); end
        next_cycle();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] push_m1;
        logic [3:0] pop_m1;
        logic [3:0] drain_m1;
        apply_reset();
        // two pushes: m0 then m1
        m0_req = 1; s_addr_ok = 1;
        next_cycle();
        m0_req = 0; m1_req = 1;
        next_cycle();
        // concurrent push+pop: push order m1,m0,m0,m1; pops return m0,m1,m1,m0
        push_m1 = 4'b1001;
        pop_m1  = 4'b0110;
        s_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            m0_req = ~push_m1[3-i]; m1_req = push_m1[3-i];
            #2;
            checks++;
            if ({m0_addr_ok | m1_addr_ok, m0_data_ok, m1_data_ok} !== {1'b1, ~pop_m1[3-i], pop_m1[3-i]}) begin
                errors++;
                $display("[TB] FAIL concurrent%0d got aok=%b dok=%b%b exp aok=1 dok=%b%b", i, m0_addr_ok | m1_addr_ok,
                         m0_data_ok, m1_data_ok, ~pop_m1[3-i], pop_m1[3-i]);
            end
            next_cycle();
        end
        // count still 2: two more fit, the next is blocked
        s_data_ok = 0; m0_req = 1; m1_req = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (m0_addr_ok !== (i < 2)) begin errors++; $display("[TB] FAIL count_hold%0d got=%b exp=%b", i, m0_addr_ok, (i < 2)); end
            next_cycle();
        end
        // drain: queue holds m0,m1,m0,m0
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        drain_m1 = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if ({m0_data_ok, m1_data_ok} !== {~drain_m1[3-i], drain_m1[3-i]}) begin
                errors++;
                $display("[TB] FAIL drain%0d got=%b%b exp=%b%b", i, m0_data_ok, m1_data_ok, ~drain_m1[3-i], drain_m1[3-i]);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset_midop();
        apply_reset();
        m0_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 3; i++) next_cycle();
        idle();
        #1;
        reset = 1;
        #1;
        s_data_ok = 1;
        #1;
        checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_data_ok got=%b exp=00", {m0_data_ok, m1_data_ok}); end
        next_cycle();
        reset = 0;
        next_cycle();
        #2;
        checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL postreset_empty got=%b exp=00", {m0_data_ok, m1_data_ok}); end
        next_cycle();
        s_data_ok = 0;
        // last_grant back to 1: with both requesting m0 wins in either build
        m0_req = 1; m1_req = 1; s_addr_ok = 1;
        #2;
        checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL postreset_grant got=%b exp=10", {m0_addr_ok, m1_addr_ok}); end
        next_cycle();
        // count cleared: three more accepts fit before full
        m1_req = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (m0_addr_ok !== (i < 3)) begin errors++; $display("[TB] FAIL postreset_fill%0d got=%b exp=%b", i, m0_addr_ok, (i < 3)); end
            next_cycle();
        end
        idle();
    endtask

    // Run every scenario in order, then report
    initial begin
        errors = 0;
        checks = 0;
        reset = 1;
        idle();
        test_reset();
        test_arbitration();
        test_order();
        test_full();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: ORD_DEPTH, default 4, outstanding-transaction order FIFO depth (power of two, >=2).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 mN_req  input  1  requester N (N=0,1) transaction request.
REQ-005 mN_wr  input  1  requester N write (1) / read (0).
REQ-006 mN_size  input  2  requester N access size (0 byte, 1 half, 2 word).
REQ-007 mN_addr  input  32  requester N address.
REQ-008 mN_wstrb  input  4  requester N write byte strobe.
REQ-009 mN_wdata  input  32  requester N write data.
REQ-010 mN_addr_ok  output  1  requester N address accepted this cycle.
REQ-011 mN_data_ok  output  1  requester N read data / write completion returned this cycle.
REQ-012 mN_rdata  output  32  requester N read data, valid with mN_data_ok.
REQ-013 s_req, s_wr, s_size[1:0], s_addr[31:0], s_wstrb[3:0], s_wdata[31:0]  output  shared sram-like master port toward the AXI bridge data port.
REQ-014 s_addr_ok, s_data_ok  input  1  shared-port handshakes; s_rdata  input  32  shared read data.

Function
REQ-015 Block SHALL share one sram-like port between two sram-like requesters, returning each data_ok to the requester that issued it, in issue order.
REQ-016 Address phase combinational: sel = arbitration winner among asserted mN_req; s_req = mN_req[sel] && !full; s_wr/size/addr/wstrb/wdata SHALL be muxed from sel.
REQ-017 mN_addr_ok = (sel==N) && mN_req && s_addr_ok && !full; the losing requester's addr_ok SHALL be 0.
REQ-018 Accept = s_req && s_addr_ok; on accept, sel SHALL be pushed into the order FIFO (1-bit entries).
REQ-019 On s_data_ok, FIFO head SHALL be popped; mN_data_ok = s_data_ok && !empty && (head==N); mN_rdata = s_rdata for both N (qualified only by data_ok).
REQ-020 Zero added latency: data_ok and addr_ok pass through in the same cycle as the shared-port handshake.
REQ-021 FIFO: read/write pointers of log2(ORD_DEPTH) bits wrapping modulo ORD_DEPTH; count of log2(ORD_DEPTH)+1 bits; full = count==ORD_DEPTH; empty = count==0.
REQ-022 When full, s_req SHALL be 0 even if s_data_ok pops in the same cycle (no bypass).
REQ-023 Same-cycle push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 s_data_ok while empty SHALL be ignored: no data_ok output, no pointer/count change.
REQ-025 Requester holds req/fields until its addr_ok; arbitration MAY switch sel while no accept occurs.
REQ-026 last_grant register SHALL update to sel only on accept.

Reset
REQ-027 reset SHALL asynchronously clear wptr, rptr, count to 0 and set last_grant to 1.
REQ-028 During/after reset all mN_addr_ok, mN_data_ok, s_req SHALL be 0 until a requester asserts req; outstanding transactions in flight at reset are discarded.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: both requesting -> sel = the requester that is not last_grant; single requester always wins.
REQ-030 ARB_ROUND_ROBIN_EN undefined: fixed priority, m0 wins whenever m0_req; last_grant still maintained but unused for arbitration.

Verification
REQ-031 Both req, s_addr_ok=1, RR build, after reset -> m0 accepted cycle 1, m1 cycle 2, m0 cycle 3 (alternation); fixed build -> m0 every cycle while m0_req.
REQ-032 m0 read 0x1000, then m1 write 0x2000; s_data_ok twice with s_rdata=0xDEADBEEF -> m0_data_ok with rdata 0xDEADBEEF first, then m1_data_ok; never swapped.
REQ-033 Four accepts with no s_data_ok (ORD_DEPTH=4) -> fifth request: s_req=0, addr_ok=0 even with concurrent s_data_ok; next cycle accepted.
REQ-034 Concurrent accept and s_data_ok at count=2 -> count stays 2; pointers wrap 3->0 correctly over 6 transactions.
REQ-035 s_data_ok pulse with empty FIFO -> m0_data_ok=m1_data_ok=0, count stays 0; reset asserted mid-operation with count=3 -> count=0, last_grant=1 immediately.
